// File: rtl/packer_pkg.sv
// packer_pkg: shared widths, FSM states and the wide-beat record for the narrow-to-wide packer
package packer_pkg;
    localparam int NB    = 32;
    localparam int WW    = 5;
    localparam int VBC_W = 8;
    localparam int DW    = NB * 8;
    localparam int WDW   = WW * DW;
    localparam int WC_W  = $clog2(WW + 1);
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [VBC_W-1:0] vbc;
        logic [WDW-1:0]   data;
    } wide_t;
endpackage

// File: rtl/packer_outreg.sv
// packer_outreg: one-entry valid/ready output register holding a wide beat
//  clk, reset_L : clock, async active-low reset
//  load, d      : capture d (only asserted while free)
//  ready        : downstream ready
//  val, q       : held wide beat
//  free         : register empty or draining this cycle
module packer_outreg
    import packer_pkg::*;
(
    input  logic  clk,
    input  logic  reset_L,
    input  logic  load,
    input  wide_t d,
    input  logic  ready,
    output logic  val,
    output wide_t q,
    output logic  free
);
    assign free = !val || ready;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            val <= 1'b0;
            q   <= '0;
        end else if (load) begin
            val <= 1'b1;
            q   <= d;
        end else if (ready) begin
            val <= 1'b0;
        end
    end
endmodule

// File: rtl/packer_fsm.sv
// packer_fsm: gathers 32B narrow beats into 160B wide beats on a valid/ready stream
//  clk, reset_L                 : clock, async active-low reset
//  i_val/i_sop/i_eop/i_vbc/i_data, i_ready : narrow input stream
//  ready                        : downstream ready
//  val/sop/eop/vbc/data         : wide output beat
//  err                          : one-cycle pulse on protocol violation
module packer_fsm
    import packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             i_val,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic [VBC_W-1:0] i_vbc,
    input  logic [DW-1:0]    i_data,
    output logic             i_ready,
    input  logic             ready,
    output logic             val,
    output logic             sop,
    output logic             eop,
    output logic [VBC_W-1:0] vbc,
    output logic [WDW-1:0]   data,
    output logic             err
);
    state_t           state, state_nx;
    logic [WDW-1:0]   acc, acc_nx, n_acc;
    logic [VBC_W-1:0] acc_vbc, acc_vbc_nx, n_vbc;
    logic [WC_W-1:0]  wcnt, wcnt_nx, n_cnt;
    logic             first, first_nx, pend_eop, pend_eop_nx, err_nx;
    logic             take, bad_vbc, short_beat, good, eop_eff, close, n_first;
    logic             load, free;
    wide_t            ld, q;

    assign i_ready    = state != HOLD;
    assign take       = i_val && i_ready;
    assign bad_vbc    = i_vbc == '0 || i_vbc > VBC_W'(NB);
    assign short_beat = i_vbc < VBC_W'(NB);
    assign good       = take && !bad_vbc && (state == FILL || i_sop);
    // an i_sop beat restarts the chunk, discarding any partial one
    assign n_vbc      = (i_sop ? '0 : acc_vbc) + i_vbc;
    assign n_cnt      = (i_sop ? '0 : wcnt) + WC_W'(1);
    assign n_first    = i_sop || first;
    // a short beat can only be the last of a packet
    assign eop_eff    = i_eop || short_beat;
    assign close      = good && (eop_eff || n_cnt == WC_W'(WW));
    // first beat ends up in the highest used slot
    assign n_acc      = {acc[WDW-DW-1:0], i_data};

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        acc_vbc_nx  = acc_vbc;
        wcnt_nx     = wcnt;
        first_nx    = first;
        pend_eop_nx = pend_eop;
        load        = 1'b0;
        ld          = '{sop: first, eop: pend_eop, vbc: acc_vbc, data: acc};
        err_nx      = take && (bad_vbc || (state == IDLE && !i_sop) || (state == FILL && i_sop) ||
                               (good && short_beat && !i_eop));
        if (state == HOLD) begin
            if (free) begin
                load       = 1'b1;
                state_nx   = pend_eop ? IDLE : FILL;
                acc_vbc_nx = '0;
                wcnt_nx    = '0;
                first_nx   = 1'b0;
            end
        end else if (good) begin
            acc_nx = n_acc;
            if (close && free) begin
                load       = 1'b1;
                ld         = '{sop: n_first, eop: eop_eff, vbc: n_vbc, data: n_acc};
                state_nx   = eop_eff ? IDLE : FILL;
                acc_vbc_nx = '0;
                wcnt_nx    = '0;
                first_nx   = 1'b0;
            end else if (close) begin
                state_nx    = HOLD;
                acc_vbc_nx  = n_vbc;
                first_nx    = n_first;
                pend_eop_nx = eop_eff;
            end else begin
                state_nx   = FILL;
                acc_vbc_nx = n_vbc;
                wcnt_nx    = n_cnt;
                first_nx   = n_first;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            acc      <= '0;
            acc_vbc  <= '0;
            wcnt     <= '0;
            first    <= 1'b0;
            pend_eop <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            acc_vbc  <= acc_vbc_nx;
            wcnt     <= wcnt_nx;
            first    <= first_nx;
            pend_eop <= pend_eop_nx;
            err      <= err_nx;
        end
    end

    packer_outreg u_outreg (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (load),
        .d       (ld),
        .ready   (ready),
        .val     (val),
        .q       (q),
        .free    (free)
    );

    assign sop  = q.sop;
    assign eop  = q.eop;
    assign vbc  = q.vbc;
    assign data = q.data;
endmodule

// File: tb/tb_packer_fsm.sv
// tb_packer_fsm: directed self-checking bench for packer_fsm
module tb_packer_fsm;
    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          i_val = 1'b0, i_sop = 1'b0, i_eop = 1'b0, ready = 1'b1;
    logic [7:0]    i_vbc = '0;
    logic [255:0]  i_data = '0;
    logic          i_ready, val, sop, eop, err;
    logic [7:0]    vbc;
    logic [1279:0] data;
    int            vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    packer_fsm dut (
        .clk     (clk),
        .reset_L (reset_L),
        .i_val   (i_val),
        .i_sop   (i_sop),
        .i_eop   (i_eop),
        .i_vbc   (i_vbc),
        .i_data  (i_data),
        .i_ready (i_ready),
        .ready   (ready),
        .val     (val),
        .sop     (sop),
        .eop     (eop),
        .vbc     (vbc),
        .data    (data),
        .err     (err)
    );

    function automatic logic [255:0] pat(int k);
        return {8{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [255:0] slot(int i);
        return data[i*256 +: 256];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic [7:0] v, input logic [255:0] d);
        i_val = 1'b1; i_sop = s; i_eop = e; i_vbc = v; i_data = d;
        @(posedge clk);
        #1;
        i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_vbc = '0; i_data = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_val", val, 0);
        chk("rst_iready", i_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_vbc", vbc, 0);
        #20 reset_L = 1'b1;
        idle();
        // single beat packet
        beat(1, 1, 20, pat(1));
        chk("t1_val", val, 1);
        chk("t1_sop", sop, 1);
        chk("t1_eop", eop, 1);
        chk("t1_vbc", vbc, 20);
        chk("t1_data", slot(0), pat(1));
        chk("t1_err", err, 0);
        idle();
        chk("t1_drain", val, 0);
        // three beat packet
        beat(1, 0, 32, pat(10));
        chk("t2_val0", val, 0);
        beat(0, 0, 32, pat(11));
        beat(0, 1, 10, pat(12));
        chk("t2_val", val, 1);
        chk("t2_vbc", vbc, 74);
        chk("t2_sopeop", {sop, eop}, 2'b11);
        chk("t2_slot2", slot(2), pat(10));
        chk("t2_slot1", slot(1), pat(11));
        chk("t2_slot0", slot(0), pat(12));
        idle();
        // seven full beats -> two wide beats
        for (int k = 0; k < 5; k++) beat(k == 0, 0, 32, pat(20 + k));
        chk("t3_w1_val", val, 1);
        chk("t3_w1_vbc", vbc, 160);
        chk("t3_w1_sopeop", {sop, eop}, 2'b10);
        chk("t3_w1_slot4", slot(4), pat(20));
        chk("t3_w1_slot0", slot(0), pat(24));
        beat(0, 0, 32, pat(25));
        chk("t3_mid_val", val, 0);
        beat(0, 1, 32, pat(26));
        chk("t3_w2_val", val, 1);
        chk("t3_w2_vbc", vbc, 64);
        chk("t3_w2_sopeop", {sop, eop}, 2'b01);
        chk("t3_w2_slot1", slot(1), pat(25));
        chk("t3_w2_slot0", slot(0), pat(26));
        idle();
        // backpressure across two full chunks
        ready = 1'b0;
        for (int k = 0; k < 5; k++) beat(k == 0, 0, 32, pat(30 + k));
        chk("t4_w1_val", val, 1);
        for (int k = 5; k < 9; k++) beat(0, 0, 32, pat(30 + k));
        chk("t4_fill_iready", i_ready, 1);
        chk("t4_held_vbc", vbc, 160);
        beat(0, 1, 32, pat(39));
        chk("t4_hold_iready", i_ready, 0);
        chk("t4_hold_val", val, 1);
        chk("t4_hold_sop", sop, 1);
        chk("t4_hold_slot4", slot(4), pat(30));
        idle();
        chk("t4_hold2_iready", i_ready, 0);
        chk("t4_hold2_slot0", slot(0), pat(34));
        ready = 1'b1;
        idle();
        chk("t4_w2_val", val, 1);
        chk("t4_w2_sopeop", {sop, eop}, 2'b01);
        chk("t4_w2_vbc", vbc, 160);
        chk("t4_w2_slot4", slot(4), pat(35));
        chk("t4_w2_slot0", slot(0), pat(39));
        chk("t4_w2_iready", i_ready, 1);
        idle();
        chk("t4_drain", val, 0);
        // protocol errors
        beat(1, 0, 32, pat(40));
        chk("t5_ok_err", err, 0);
        beat(1, 0, 32, pat(41));
        chk("t5_sop_mid_err", err, 1);
        beat(0, 1, 32, pat(42));
        chk("t5_restart_err", err, 0);
        chk("t5_restart_vbc", vbc, 64);
        chk("t5_restart_sopeop", {sop, eop}, 2'b11);
        chk("t5_restart_slot1", slot(1), pat(41));
        chk("t5_restart_slot0", slot(0), pat(42));
        beat(1, 1, 0, pat(43));
        chk("t5_vbc0_err", err, 1);
        chk("t5_vbc0_val", val, 0);
        beat(0, 1, 20, pat(44));
        chk("t5_nosop_err", err, 1);
        chk("t5_nosop_val", val, 0);
        beat(1, 0, 20, pat(45));
        chk("t5_short_err", err, 1);
        chk("t5_short_val", val, 1);
        chk("t5_short_sopeop", {sop, eop}, 2'b11);
        chk("t5_short_vbc", vbc, 20);
        beat(1, 1, 33, pat(46));
        chk("t5_big_err", err, 1);
        chk("t5_big_val", val, 0);
        idle();
        chk("t5_err_clear", err, 0);
        // async reset mid-packet with a held wide beat
        ready = 1'b0;
        for (int k = 0; k < 5; k++) beat(k == 0, 0, 32, pat(50 + k));
        beat(0, 0, 32, pat(55));
        chk("t6_pre_val", val, 1);
        #2 reset_L = 1'b0;
        #1;
        chk("t6_rst_val", val, 0);
        chk("t6_rst_iready", i_ready, 1);
        chk("t6_rst_vbc", vbc, 0);
        @(negedge clk);
        reset_L = 1'b1;
        ready = 1'b1;
        #1;
        beat(1, 1, 5, pat(60));
        chk("t6_post_val", val, 1);
        chk("t6_post_vbc", vbc, 5);
        chk("t6_post_sopeop", {sop, eop}, 2'b11);
        chk("t6_post_slot0", slot(0), pat(60));
        chk("t6_post_err", err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
